// File: rtl/sdram_responder.sv
// SDR SDRAM device model: decodes the command pins, tracks open rows per bank, stores data on chip.
// Read beats appear CL edges after issue, and read DQM has a latency of 2; sdram_clke low freezes every register.
module sdram_responder #(
    parameter int W_BANKSEL   = 2,
    parameter int W_ADDR      = 13,
    parameter int W_DATA      = 16,
    parameter int W_ROW       = 13,
    parameter int W_COL       = 10,
    parameter int W_MEM_ADDR  = 12,
    parameter int CAS_LATENCY = 2,
    parameter int BURST_LEN   = 8
) (
    input  logic                   clk_sys,
    input  logic                   rst_n_por,
    input  logic [W_BANKSEL-1:0]   sdram_ba,
    input  logic [W_ADDR-1:0]      sdram_a,
    input  logic [W_DATA/8-1:0]    sdram_dqm,
    input  logic [W_DATA-1:0]      sdram_dq_o,
    output logic [W_DATA-1:0]      sdram_dq_i,
    input  logic                   sdram_clke,
    input  logic                   sdram_cs_n,
    input  logic                   sdram_ras_n,
    input  logic                   sdram_cas_n,
    input  logic                   sdram_we_n,
    output logic [3:0]             err,
    output logic [15:0]            refresh_count
);
    localparam int W_DQM = W_DATA / 8;
    localparam int NBANK = 1 << W_BANKSEL;
    localparam logic [1:0] BL_LOG2_RST = (BURST_LEN == 8) ? 2'd3 : (BURST_LEN == 4) ? 2'd2 :
                                         (BURST_LEN == 2) ? 2'd1 : 2'd0;
    localparam logic CL3_RST = (CAS_LATENCY == 3);

    logic [NBANK-1:0]      r_bank_act, r_rcd;
    logic [W_ROW-1:0]      r_bank_row [NBANK];
    logic                  r_cl3;
    logic [1:0]            r_bl_log2;
    logic                  r_bst_act, r_bst_wr, r_bst_ok, r_bst_ap;
    logic [W_BANKSEL-1:0]  r_bst_bank, r_ap_bank;
    logic [W_ROW-1:0]      r_bst_row;
    logic [W_COL-1:0]      r_bst_col;
    logic [2:0]            r_bst_left;
    logic                  r_ap_pend;
    logic                  r_rd_vld;
    logic [W_DATA-1:0]     r_rd_dat, r_p2, r_p3, r_dq;
    logic [W_DQM-1:0]      r_dqm1, r_dqm2;
    logic [3:0]            r_err;
    logic [15:0]           r_ref_cnt;
    logic [W_DATA-1:0]     r_mem [2**W_MEM_ADDR];

    logic [3:0]            w_cmd;
    logic                  w_is_act, w_is_rd, w_is_wr, w_is_pre, w_is_ref, w_is_mrs, w_is_bst;
    logic                  w_new, w_term;
    logic [NBANK-1:0]      w_ap_clr, w_act_eff, w_act_next;
    logic [W_COL-1:0]      w_bl_mask, w_next_col;
    logic                  w_beat_vld, w_beat_wr, w_beat_ok, w_beat_last, w_beat_ap;
    logic [W_BANKSEL-1:0]  w_beat_bank;
    logic [W_ROW-1:0]      w_beat_row;
    logic [W_COL-1:0]      w_beat_col;
    logic [W_MEM_ADDR-1:0] w_mem_addr;
    logic [W_DATA-1:0]     w_p1, w_dqm_mask;

    assign w_cmd    = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign w_is_act = (w_cmd == 4'b0011);
    assign w_is_rd  = (w_cmd == 4'b0101);
    assign w_is_wr  = (w_cmd == 4'b0100);
    assign w_is_pre = (w_cmd == 4'b0010);
    assign w_is_ref = (w_cmd == 4'b0001);
    assign w_is_mrs = (w_cmd == 4'b0000);
    assign w_is_bst = (w_cmd == 4'b0110);
    assign w_new    = w_is_rd | w_is_wr;
    assign w_term   = r_bst_act & (w_new | w_is_bst |
                      (w_is_pre & (sdram_a[10] | (sdram_ba == r_bst_bank))));

    // Auto-precharge from the previous edge retires before this edge's command is judged.
    assign w_ap_clr  = r_ap_pend ? (NBANK'(1) << r_ap_bank) : '0;
    assign w_act_eff = r_bank_act & ~w_ap_clr;
    assign w_bl_mask = W_COL'((4'd1 << r_bl_log2) - 4'd1);

    always_comb begin
        w_act_next = w_act_eff;
        if (w_is_act)
            w_act_next[sdram_ba] = 1'b1;
        if (w_is_pre) begin
            if (sdram_a[10])
                w_act_next = '0;
            else
                w_act_next[sdram_ba] = 1'b0;
        end
    end

    always_comb begin
        w_beat_vld  = 1'b0;
        w_beat_wr   = r_bst_wr;
        w_beat_ok   = r_bst_ok;
        w_beat_last = 1'b0;
        w_beat_ap   = r_bst_ap;
        w_beat_bank = r_bst_bank;
        w_beat_row  = r_bst_row;
        w_beat_col  = r_bst_col;
        if (w_new) begin
            w_beat_vld  = 1'b1;
            w_beat_wr   = w_is_wr;
            w_beat_ok   = w_act_eff[sdram_ba];
            w_beat_last = (r_bl_log2 == 2'd0);
            w_beat_ap   = sdram_a[10];
            w_beat_bank = sdram_ba;
            w_beat_row  = r_bank_row[sdram_ba];
            w_beat_col  = sdram_a[W_COL-1:0];
        end else if (r_bst_act && !w_term) begin
            w_beat_vld  = 1'b1;
            w_beat_last = (r_bst_left == 3'd1);
        end
    end

    // Sequential bursts wrap inside the BL-aligned column block.
    assign w_next_col = (w_beat_col & ~w_bl_mask) | ((w_beat_col + 1'b1) & w_bl_mask);
    assign w_mem_addr = W_MEM_ADDR'({w_beat_bank, w_beat_row, w_beat_col});
    assign w_p1       = r_rd_vld ? r_rd_dat : '0;

    always_comb begin
        w_dqm_mask = '0;
        for (int j = 0; j < W_DQM; j++)
            w_dqm_mask[j*8 +: 8] = {8{r_dqm2[j]}};
    end

    always_ff @(posedge clk_sys) begin
        if (sdram_clke) begin
            if (w_is_act)
                r_bank_row[sdram_ba] <= sdram_a[W_ROW-1:0];
            r_rd_dat <= r_mem[w_mem_addr];
            if (w_beat_vld && w_beat_wr && w_beat_ok) begin
                for (int j = 0; j < W_DQM; j++)
                    if (!sdram_dqm[j])
                        r_mem[w_mem_addr][j*8 +: 8] <= sdram_dq_o[j*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n_por) begin
        if (!rst_n_por) begin
            r_bank_act <= '0;
            r_rcd      <= '0;
            r_cl3      <= CL3_RST;
            r_bl_log2  <= BL_LOG2_RST;
            r_bst_act  <= 1'b0;
            r_bst_wr   <= 1'b0;
            r_bst_ok   <= 1'b0;
            r_bst_ap   <= 1'b0;
            r_bst_bank <= '0;
            r_bst_row  <= '0;
            r_bst_col  <= '0;
            r_bst_left <= '0;
            r_ap_pend  <= 1'b0;
            r_ap_bank  <= '0;
            r_rd_vld   <= 1'b0;
            r_p2       <= '0;
            r_p3       <= '0;
            r_dq       <= '0;
            r_dqm1     <= '0;
            r_dqm2     <= '0;
            r_err      <= '0;
            r_ref_cnt  <= '0;
        end else if (sdram_clke) begin
            r_bank_act <= w_act_next;
            r_rcd      <= w_is_act ? (NBANK'(1) << sdram_ba) : '0;
            r_err      <= r_err | {w_new & r_rcd[sdram_ba],
                                   (w_is_mrs | w_is_ref) & (|w_act_eff),
                                   w_is_act & w_act_eff[sdram_ba],
                                   w_new & ~w_act_eff[sdram_ba]};
            if (w_is_ref && r_ref_cnt != 16'hffff)
                r_ref_cnt <= r_ref_cnt + 16'd1;
            if (w_is_mrs) begin
                r_cl3     <= (sdram_a[6:4] == 3'd3);
                r_bl_log2 <= sdram_a[2] ? 2'd3 : sdram_a[1:0];
            end
            if (w_new) begin
                r_bst_wr   <= w_is_wr;
                r_bst_ok   <= w_act_eff[sdram_ba];
                r_bst_ap   <= sdram_a[10];
                r_bst_bank <= sdram_ba;
                r_bst_row  <= r_bank_row[sdram_ba];
                r_bst_left <= 3'((4'd1 << r_bl_log2) - 4'd1);
            end else begin
                r_bst_left <= r_bst_left - 3'd1;
            end
            r_bst_act <= w_beat_vld & ~w_beat_last;
            if (w_beat_vld)
                r_bst_col <= w_next_col;
            r_ap_pend <= w_beat_vld & w_beat_last & w_beat_ap;
            r_ap_bank <= w_beat_bank;
            r_rd_vld  <= w_beat_vld & ~w_beat_wr & w_beat_ok;
            r_p2      <= w_p1;
            r_p3      <= r_p2;
            r_dqm1    <= sdram_dqm;
            r_dqm2    <= r_dqm1;
            r_dq      <= (r_cl3 ? r_p3 : r_p2) & ~w_dqm_mask;
        end
    end

    assign sdram_dq_i    = r_dq;
    assign err           = r_err;
    assign refresh_count = r_ref_cnt;
endmodule
